// File: rtl/integrator_pkg.sv
// -----------------------------------------------------------------------------
// integrator_pkg
// Shared definitions for the integrator_cascade block:
//   - encodings of the FORM parameter (forward / backward integrator)
//   - encodings of the SAT_EN parameter (wrap / clamp on range violation)
//   - per-stage range flag record
//   - helpers giving the signed limits of an accumulator of a given width
// No ports: package only.
// -----------------------------------------------------------------------------
package integrator_pkg;

  // Integrator form: forward uses the previous sample, backward the current one.
  localparam int FORM_FORWARD  = 0;
  localparam int FORM_BACKWARD = 1;

  // Range handling: keep the low bits (two's-complement wrap) or clamp.
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Range violation seen by one stage for the current sample.
  typedef struct packed {
    logic ovf;
    logic unf;
  } range_flags_t;

  // Largest value of a signed field of the given width (width 2..31).
  function automatic int acc_max_f(input int width);
    return (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
  endfunction

  // Most negative value of a signed field of the given width (width 2..31).
  function automatic int acc_min_f(input int width);
    return -(32'sd1 <<< (width - 32'sd1));
  endfunction

endpackage

// File: rtl/integrator_stage.sv
// -----------------------------------------------------------------------------
// integrator_stage
// Combinational datapath of one integrator stage: adds the stage input to the
// stage accumulator at one extra bit of precision, detects overflow/underflow
// against the accumulator limits and produces either the wrapped or the
// clamped result. The accumulator register itself lives in the parent.
// Ports:
//   acc    - current accumulator value of this stage
//   addend - value to integrate this sample (sample or previous stage)
//   sum    - next accumulator value after wrap/clamp
//   flags  - overflow / underflow of the unclamped sum
// -----------------------------------------------------------------------------
module integrator_stage
  import integrator_pkg::*;
#(
  parameter int ACC_BIT_WIDTH = 5,
  parameter int SAT_EN        = 0
) (
  input  logic signed [ACC_BIT_WIDTH-1:0] acc,
  input  logic signed [ACC_BIT_WIDTH-1:0] addend,
  output logic signed [ACC_BIT_WIDTH-1:0] sum,
  output range_flags_t                    flags
);

  localparam int SUM_W = ACC_BIT_WIDTH + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(acc_max_f(ACC_BIT_WIDTH));
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(acc_min_f(ACC_BIT_WIDTH));

  logic signed [SUM_W-1:0] wide_s;

  // Full-precision sum: one guard bit so that no addition can itself overflow.
  always_comb begin
    wide_s = SUM_W'(acc) + SUM_W'(addend);
  end

  // Range detection and wrap/clamp selection of the stage result.
  always_comb begin
    flags.ovf = (wide_s > ACC_MAX);
    flags.unf = (wide_s < ACC_MIN);
    if ((SAT_EN == SAT_CLAMP) && flags.ovf) begin
      sum = ACC_MAX[ACC_BIT_WIDTH-1:0];
    end else if ((SAT_EN == SAT_CLAMP) && flags.unf) begin
      sum = ACC_MIN[ACC_BIT_WIDTH-1:0];
    end else begin
      // Dropping the guard bit is exactly two's-complement wrap.
      sum = wide_s[ACC_BIT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/integrator_cascade.sv
// -----------------------------------------------------------------------------
// integrator_cascade
// Cascade of STAGES integrators clocked by MCLK_I and advanced once per rising
// edge of the slower, synchronous sample clock CLK_I. Each stage is either a
// forward (y[n]=y[n-1]+x[n-1]) or backward (y[n]=y[n-1]+x[n]) integrator, with
// two's-complement wrap or saturation on range violation.
// Ports:
//   MCLK_I  - master clock, all logic on its rising edge
//   RST_I   - synchronous active-high reset
//   CLK_I   - sample clock (at most MCLK_I/2)
//   DATA_I  - signed input sample
//   CLR_I   - synchronous clear of integrator state and outputs
//   CLK_O   - CLK_I delayed one MCLK_I, aligned with DATA_O
//   DATA_O  - last-stage accumulator, updated once per sample
//   VALID_O - one-MCLK_I pulse when DATA_O updates
//   OFDET_O - some stage overflowed on the current output sample
//   UFDET_O - some stage underflowed on the current output sample
// -----------------------------------------------------------------------------
module integrator_cascade
  import integrator_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 5,
  parameter int ACC_BIT_WIDTH  = 5,
  parameter int STAGES         = 1,
  parameter int FORM           = 0,
  parameter int SAT_EN         = 0
) (
  input  logic                             MCLK_I,
  input  logic                             RST_I,
  input  logic                             CLK_I,
  input  logic signed [DATA_BIT_WIDTH-1:0] DATA_I,
  input  logic                             CLR_I,
  output logic                             CLK_O,
  output logic signed [ACC_BIT_WIDTH-1:0]  DATA_O,
  output logic                             VALID_O,
  output logic                             OFDET_O,
  output logic                             UFDET_O
);

  logic                            clk_d_r;
  logic                            arm_r;
  logic                            strobe_s;
  logic signed [ACC_BIT_WIDTH-1:0] stage0_in_s;
  logic signed [ACC_BIT_WIDTH-1:0] last_sum_s;
  logic [STAGES-1:0]               ovf_vec_s;
  logic [STAGES-1:0]               unf_vec_s;
  logic                            ovf_any_s;
  logic                            unf_any_s;

  // Sample-clock history. arm_r stays low until CLK_I has been seen low after
  // reset, so a CLK_I already high when reset releases does not count as an edge.
  always_ff @(posedge MCLK_I) begin
    if (RST_I) begin
      clk_d_r <= 1'b0;
      arm_r   <= 1'b0;
    end else begin
      clk_d_r <= CLK_I;
      arm_r   <= arm_r | ~CLK_I;
    end
  end

  // One-MCLK_I strobe in the cycle following each qualified CLK_I rise.
  always_comb begin
    strobe_s = CLK_I & ~clk_d_r & arm_r;
  end

  // First-stage input: the current sample (backward) or the sample captured
  // on the previous strobe (forward).
  generate
    if (FORM == FORM_BACKWARD) begin : g_in_bwd
      always_comb begin
        stage0_in_s = ACC_BIT_WIDTH'(DATA_I);
      end
    end else begin : g_in_fwd
      logic signed [DATA_BIT_WIDTH-1:0] din_r;

      // Previous sample register, cleared together with the integrator state.
      always_ff @(posedge MCLK_I) begin
        if (RST_I) begin
          din_r <= {DATA_BIT_WIDTH{1'b0}};
        end else if (CLR_I) begin
          din_r <= {DATA_BIT_WIDTH{1'b0}};
        end else if (strobe_s) begin
          din_r <= DATA_I;
        end else begin
          din_r <= din_r;
        end
      end

      // Sign-extend the delayed sample to accumulator width.
      always_comb begin
        stage0_in_s = ACC_BIT_WIDTH'(din_r);
      end
    end
  endgenerate

  // Integrator chain. Backward stages take the freshly computed result of the
  // previous stage (same strobe); forward stages take its registered value,
  // which adds one sample of delay per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic signed [ACC_BIT_WIDTH-1:0] acc_r;
    logic signed [ACC_BIT_WIDTH-1:0] addend_s;
    logic signed [ACC_BIT_WIDTH-1:0] sum_s;
    range_flags_t                    flags_s;

    if (k == 0) begin : g_src_in
      assign addend_s = stage0_in_s;
    end else if (FORM == FORM_BACKWARD) begin : g_src_new
      assign addend_s = g_stage[k-1].sum_s;
    end else begin : g_src_old
      assign addend_s = g_stage[k-1].acc_r;
    end

    integrator_stage #(
      .ACC_BIT_WIDTH (ACC_BIT_WIDTH),
      .SAT_EN        (SAT_EN)
    ) u_stage (
      .acc    (acc_r),
      .addend (addend_s),
      .sum    (sum_s),
      .flags  (flags_s)
    );

    // Stage accumulator: zeroed by reset or clear, advanced only on a strobe.
    always_ff @(posedge MCLK_I) begin
      if (RST_I) begin
        acc_r <= {ACC_BIT_WIDTH{1'b0}};
      end else if (CLR_I) begin
        acc_r <= {ACC_BIT_WIDTH{1'b0}};
      end else if (strobe_s) begin
        acc_r <= sum_s;
      end else begin
        acc_r <= acc_r;
      end
    end

    assign ovf_vec_s[k] = flags_s.ovf;
    assign unf_vec_s[k] = flags_s.unf;

    if (k == STAGES - 1) begin : g_last
      assign last_sum_s = sum_s;
    end
  end

  // Range flags of any stage for the sample being produced.
  always_comb begin
    ovf_any_s = |ovf_vec_s;
    unf_any_s = |unf_vec_s;
  end

  // Output registers: loaded on a strobe, held otherwise. A clear zeroes them
  // and suppresses the VALID_O pulse even when it coincides with a strobe.
  always_ff @(posedge MCLK_I) begin
    if (RST_I) begin
      DATA_O  <= {ACC_BIT_WIDTH{1'b0}};
      VALID_O <= 1'b0;
      OFDET_O <= 1'b0;
      UFDET_O <= 1'b0;
    end else if (CLR_I) begin
      DATA_O  <= {ACC_BIT_WIDTH{1'b0}};
      VALID_O <= 1'b0;
      OFDET_O <= 1'b0;
      UFDET_O <= 1'b0;
    end else if (strobe_s) begin
      DATA_O  <= last_sum_s;
      VALID_O <= 1'b1;
      OFDET_O <= ovf_any_s;
      UFDET_O <= unf_any_s;
    end else begin
      DATA_O  <= DATA_O;
      VALID_O <= 1'b0;
      OFDET_O <= OFDET_O;
      UFDET_O <= UFDET_O;
    end
  end

  // The delayed sample clock rises in the same cycle as VALID_O.
  assign CLK_O = clk_d_r;

endmodule

// File: tb/tb_integrator_cascade.sv
`timescale 1ns/1ps
// Self-checking bench for integrator_cascade: five parameterisations share the
// master clock, sample clock and reset; each has its own data and clear.
module tb_integrator_cascade;

  localparam int NDUT = 5;
  int cfg_aw  [NDUT] = '{5, 5, 12, 8, 6};
  int cfg_dw  [NDUT] = '{5, 5, 5, 6, 4};
  int cfg_st  [NDUT] = '{1, 1, 2, 3, 3};
  int cfg_fm  [NDUT] = '{0, 0, 1, 0, 1};
  int cfg_sat [NDUT] = '{0, 1, 0, 1, 0};

  logic mclk = 1'b0;
  logic rst;
  logic clk_i;
  logic [NDUT-1:0] clr_v;
  int din_v [NDUT];

  logic signed [4:0]  d0, d1, d2;
  logic signed [5:0]  d3;
  logic signed [3:0]  d4;
  logic signed [4:0]  o0, o1;
  logic signed [11:0] o2;
  logic signed [7:0]  o3;
  logic signed [5:0]  o4;
  logic [NDUT-1:0] clko_v, valid_v, of_v, uf_v;
  logic signed [31:0] out_w [NDUT];

  assign d0 = 5'(din_v[0]);
  assign d1 = 5'(din_v[1]);
  assign d2 = 5'(din_v[2]);
  assign d3 = 6'(din_v[3]);
  assign d4 = 4'(din_v[4]);
  assign out_w[0] = 32'(o0);
  assign out_w[1] = 32'(o1);
  assign out_w[2] = 32'(o2);
  assign out_w[3] = 32'(o3);
  assign out_w[4] = 32'(o4);

  always #5 mclk = ~mclk;

  integrator_cascade u0 (
    .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(d0), .CLR_I(clr_v[0]),
    .CLK_O(clko_v[0]), .DATA_O(o0), .VALID_O(valid_v[0]), .OFDET_O(of_v[0]), .UFDET_O(uf_v[0]));

  integrator_cascade #(.SAT_EN(1)) u1 (
    .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(d1), .CLR_I(clr_v[1]),
    .CLK_O(clko_v[1]), .DATA_O(o1), .VALID_O(valid_v[1]), .OFDET_O(of_v[1]), .UFDET_O(uf_v[1]));

  integrator_cascade #(.ACC_BIT_WIDTH(12), .STAGES(2), .FORM(1)) u2 (
    .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(d2), .CLR_I(clr_v[2]),
    .CLK_O(clko_v[2]), .DATA_O(o2), .VALID_O(valid_v[2]), .OFDET_O(of_v[2]), .UFDET_O(uf_v[2]));

  integrator_cascade #(.DATA_BIT_WIDTH(6), .ACC_BIT_WIDTH(8), .STAGES(3), .FORM(0), .SAT_EN(1)) u3 (
    .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(d3), .CLR_I(clr_v[3]),
    .CLK_O(clko_v[3]), .DATA_O(o3), .VALID_O(valid_v[3]), .OFDET_O(of_v[3]), .UFDET_O(uf_v[3]));

  integrator_cascade #(.DATA_BIT_WIDTH(4), .ACC_BIT_WIDTH(6), .STAGES(3), .FORM(1), .SAT_EN(0)) u4 (
    .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(d4), .CLR_I(clr_v[4]),
    .CLK_O(clko_v[4]), .DATA_O(o4), .VALID_O(valid_v[4]), .OFDET_O(of_v[4]), .UFDET_O(uf_v[4]));

  int errors;
  int checks;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_acc [NDUT][8];
  int m_din [NDUT];
  int m_out [NDUT];
  bit m_of [NDUT];
  bit m_uf [NDUT];
  bit m_valid [NDUT];

  function automatic int wrap_to(input int s, input int aw);
    int span;
    int lo;
    int r;
    span = 1 << aw;
    lo = -(1 << (aw - 1));
    r = (s - lo) % span;
    if (r < 0) r += span;
    return r + lo;
  endfunction

  task automatic model_zero(input int i);
    for (int k = 0; k < 8; k++) m_acc[i][k] = 0;
    m_din[i] = 0;
    m_out[i] = 0;
    m_of[i] = 1'b0;
    m_uf[i] = 1'b0;
  endtask

  // One sample through the cascade using plain integer arithmetic.
  task automatic model_step(input int i);
    int hi, lo, x, add, s;
    int old [8];
    bit of, uf;
    hi = (1 << (cfg_aw[i] - 1)) - 1;
    lo = -(1 << (cfg_aw[i] - 1));
    x = din_v[i];
    of = 1'b0;
    uf = 1'b0;
    for (int k = 0; k < 8; k++) old[k] = m_acc[i][k];
    for (int k = 0; k < cfg_st[i]; k++) begin
      if (k == 0) add = (cfg_fm[i] == 1) ? x : m_din[i];
      else        add = (cfg_fm[i] == 1) ? m_acc[i][k-1] : old[k-1];
      s = old[k] + add;
      if (s > hi) of = 1'b1;
      if (s < lo) uf = 1'b1;
      if (s > hi || s < lo) begin
        if (cfg_sat[i] == 1) s = (s > hi) ? hi : lo;
        else s = wrap_to(s, cfg_aw[i]);
      end
      m_acc[i][k] = s;
    end
    m_din[i] = x;
    m_out[i] = m_acc[i][cfg_st[i] - 1];
    m_of[i] = of;
    m_uf[i] = uf;
  endtask

  // One sample clock period (2 high, 2 low) with checks after the strobe and
  // one cycle later. Entered and left at a negedge with CLK_I low.
  task automatic sample(input logic [NDUT-1:0] clrm);
    clk_i = 1'b1;
    clr_v = clrm;
    @(posedge mclk);
    for (int i = 0; i < NDUT; i++) begin
      if (clrm[i]) begin
        model_zero(i);
        m_valid[i] = 1'b0;
      end else begin
        model_step(i);
        m_valid[i] = 1'b1;
      end
    end
    @(negedge mclk);
    clr_v = '0;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("out%0d", i), out_w[i], m_out[i]);
      check($sformatf("valid%0d", i), 32'(valid_v[i]), 32'(m_valid[i]));
      check($sformatf("of%0d", i), 32'(of_v[i]), 32'(m_of[i]));
      check($sformatf("uf%0d", i), 32'(uf_v[i]), 32'(m_uf[i]));
      check($sformatf("clko%0d", i), 32'(clko_v[i]), 32'sd1);
    end
    @(posedge mclk);
    @(negedge mclk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("hold_out%0d", i), out_w[i], m_out[i]);
      check($sformatf("hold_valid%0d", i), 32'(valid_v[i]), 32'sd0);
      check($sformatf("hold_of%0d", i), 32'(of_v[i]), 32'(m_of[i]));
      check($sformatf("hold_uf%0d", i), 32'(uf_v[i]), 32'(m_uf[i]));
    end
    clk_i = 1'b0;
    repeat (2) begin
      @(posedge mclk);
      @(negedge mclk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_out%0d", tag, i), out_w[i], 32'sd0);
      check($sformatf("%s_valid%0d", tag, i), 32'(valid_v[i]), 32'sd0);
      check($sformatf("%s_of%0d", tag, i), 32'(of_v[i]), 32'sd0);
      check($sformatf("%s_uf%0d", tag, i), 32'(uf_v[i]), 32'sd0);
      check($sformatf("%s_clko%0d", tag, i), 32'(clko_v[i]), 32'sd0);
    end
  endtask

  typedef struct {
    int d0; int e0; bit of0;
    int d1; int e1; bit uf1;
    int d2; int e2;
  } vec_t;
  vec_t tab [18];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int extra;
    int n;
    logic [NDUT-1:0] clrm;

    // Expected ramps from a fresh reset, one row per sample.
    for (int r = 0; r < 18; r++) begin
      n = r + 1;
      tab[r].d0 = 1;
      tab[r].e0 = (n <= 16) ? n - 1 : n - 33;
      tab[r].of0 = (n == 17);
      tab[r].d1 = -1;
      tab[r].e1 = (n <= 17) ? -(n - 1) : -16;
      tab[r].uf1 = (n >= 18);
      tab[r].d2 = 1;
      tab[r].e2 = n * (n + 1) / 2;
    end

    errors = 0;
    checks = 0;
    rst = 1'b1;
    clk_i = 1'b0;
    clr_v = '0;
    for (int i = 0; i < NDUT; i++) begin
      din_v[i] = 0;
      model_zero(i);
    end
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check_all_zero("rst");
    rst = 1'b0;
    repeat (2) begin
      @(posedge mclk);
      @(negedge mclk);
    end

    // Table-driven ramps: wrap ramp, saturating ramp, triangular cascade.
    for (int r = 0; r < 18; r++) begin
      din_v[0] = tab[r].d0;
      din_v[1] = tab[r].d1;
      din_v[2] = tab[r].d2;
      din_v[3] = 5;
      din_v[4] = -3;
      sample('0);
      check($sformatf("tab_out0_r%0d", r), out_w[0], tab[r].e0);
      check($sformatf("tab_of0_r%0d", r), 32'(of_v[0]), 32'(tab[r].of0));
      check($sformatf("tab_out1_r%0d", r), out_w[1], tab[r].e1);
      check($sformatf("tab_uf1_r%0d", r), 32'(uf_v[1]), 32'(tab[r].uf1));
      check($sformatf("tab_of1_r%0d", r), 32'(of_v[1]), 32'sd0);
      check($sformatf("tab_out2_r%0d", r), out_w[2], tab[r].e2);
    end

    // Reset for 20 cycles during a sample, released with CLK_I still high.
    clk_i = 1'b1;
    rst = 1'b1;
    @(posedge mclk);
    for (int i = 0; i < NDUT; i++) model_zero(i);
    repeat (19) @(posedge mclk);
    @(negedge mclk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    repeat (6) begin
      @(posedge mclk);
      @(negedge mclk);
      check("rel_valid0", 32'(valid_v[0]), 32'sd0);
      check("rel_out0", out_w[0], 32'sd0);
    end
    clk_i = 1'b0;
    repeat (2) begin
      @(posedge mclk);
      @(negedge mclk);
    end

    // Ramp to 7, clear in a strobe cycle, ramp restarts.
    din_v[0] = 1;
    for (int r = 0; r < 8; r++) sample('0);
    check("pre_clr_out0", out_w[0], 32'sd7);
    sample(5'b00001);
    check("clr_out0", out_w[0], 32'sd0);
    check("clr_valid0", 32'(valid_v[0]), 32'sd0);
    sample('0);
    check("restart_a_out0", out_w[0], 32'sd0);
    sample('0);
    check("restart_b_out0", out_w[0], 32'sd1);

    // Randomised samples with occasional clears, checked against the model.
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < NDUT; i++) begin
        din_v[i] = int'($urandom_range(0, (1 << cfg_dw[i]) - 1)) - (1 << (cfg_dw[i] - 1));
        clrm[i] = ($urandom_range(0, 15) == 0);
      end
      sample(clrm);
    end

    // Slow sample clock: 64 MCLK_I period, VALID_O one cycle wide per period.
    check("p64_clko_pre", 32'(clko_v[0]), 32'sd0);
    for (int p = 0; p < 3; p++) begin
      clk_i = 1'b1;
      extra = 0;
      for (int c = 0; c < 64; c++) begin
        @(posedge mclk);
        if (c == 0) begin
          for (int i = 0; i < NDUT; i++) model_step(i);
        end
        @(negedge mclk);
        if (c == 0) begin
          check("p64_valid", 32'(valid_v[0]), 32'sd1);
          check("p64_clko", 32'(clko_v[0]), 32'sd1);
          check("p64_out0", out_w[0], m_out[0]);
          check("p64_out3", out_w[3], m_out[3]);
        end else if (valid_v[0] !== 1'b0) begin
          extra++;
        end
        if (c == 31) clk_i = 1'b0;
      end
      check("p64_extra_valid", extra, 32'sd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
